shot_scheduler: RTL and testbench

//  Owns the shared pool of on-screen bullet slots for the 1v1 shooting game. It

---
 rtl/shot_scheduler_pkg.sv | 36 +++
 rtl/shot_scheduler_rr_arb2.sv | 33 +++
 rtl/shot_scheduler.sv | 122 ++++++++++++
 tb/tb_shot_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_scheduler_pkg.sv
// Shared game constants and slot record for the bullet scheduler and its
// display-side consumers.
package shot_scheduler_pkg;

  localparam int SLOTS    = 4;
  localparam int X_W      = 10;
  localparam int P1_X     = 40;
  localparam int P2_X     = 600;
  localparam int X_MAX    = 640;
  localparam int SPEED    = 4;
  localparam int COOLDOWN = 8;

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CD_W  = $clog2(COOLDOWN + 1);

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

  typedef struct packed {
    logic           valid;
    logic           owner;
    logic [X_W-1:0] x;
    logic [X_W-1:0] y;
  } slot_t;

  // Lowest-index slot whose valid bit is clear; only meaningful when one exists.
  function automatic logic [IDX_W-1:0] first_free(input logic [SLOTS-1:0] valid);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shot_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer remembers the winner of the
// last contested grant, so alternation applies only when both players collide.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_reg;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else if (en && (&req)) begin
      last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/shot_scheduler.sv
// Shared bullet-slot pool: edge-detected fire requests, round-robin grant into
// the lowest free slot, per-frame movement and freeing on hit or screen exit.
module shot_scheduler
  import shot_scheduler_pkg::*;
(
  input  logic                 board_clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [1:0]           fire_req,
  input  logic [X_W-1:0]       p1_y,
  input  logic [X_W-1:0]       p2_y,
  input  logic [SLOTS-1:0]     hit_clr,
  output logic [1:0]           fire_ack,
  output logic [SLOTS-1:0]     slot_valid,
  output logic [SLOTS-1:0]     slot_owner,
  output logic [SLOTS*X_W-1:0] slot_x,
  output logic [SLOTS*X_W-1:0] slot_y,
  output logic                 pool_full
);

  logic [1:0]            fire_prev_reg;
  logic [1:0]            pending_reg, pending_next;
  logic [1:0]            fire_ack_reg;
  logic [1:0]            cd_zero, req, grant;
  logic [1:0][CD_W-1:0]  cooldown_reg, cooldown_next;
  slot_t [SLOTS-1:0]     slot_reg, slot_next;
  logic [SLOTS-1:0]      valid_vec, valid_next_vec;
  logic [IDX_W-1:0]      free_idx;
  logic                  any_free;
  logic                  pool_full_reg;

  assign any_free     = ~(&valid_vec);
  assign free_idx     = first_free(valid_vec);
  assign req          = pending_reg & cd_zero;
  // Edges arriving while a request is already pending (or being granted) are dropped.
  assign pending_next = (pending_reg | (fire_req & ~fire_prev_reg)) & ~grant;

  rr_arb2 u_arb (
    .clk   (board_clk),
    .reset (reset),
    .en    (any_free),
    .req   (req),
    .grant (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      assign cd_zero[gi] = (cooldown_reg[gi] == '0);

      always_comb begin
        cooldown_next[gi] = cooldown_reg[gi];
        if (grant[gi]) begin
          cooldown_next[gi] = CD_W'(COOLDOWN);
        end else if (tick && !cd_zero[gi]) begin
          cooldown_next[gi] = cooldown_reg[gi] - 1'b1;
        end
      end
    end

    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      slot_t        cur, nxt;
      logic [X_W:0] x_fwd;

      assign cur   = slot_reg[gi];
      assign x_fwd = {1'b0, cur.x} + (X_W + 1)'(SPEED);

      always_comb begin
        nxt = cur;
        if (hit_clr[gi] && cur.valid) begin
          nxt.valid = 1'b0;
        end else if ((|grant) && (free_idx == IDX_W'(gi))) begin
          nxt.valid = 1'b1;
          nxt.owner = grant[1] ? OWNER_P2 : OWNER_P1;
          nxt.x     = grant[1] ? X_W'(P2_X) : X_W'(P1_X);
          nxt.y     = grant[1] ? p2_y : p1_y;
        end else if (tick && cur.valid) begin
          if (cur.owner == OWNER_P1) begin
            if (x_fwd >= (X_W + 1)'(X_MAX)) nxt.valid = 1'b0;
            else                            nxt.x     = x_fwd[X_W-1:0];
          end else begin
            // Compare before subtracting so a bullet near the left edge never wraps.
            if (cur.x < X_W'(SPEED)) nxt.valid = 1'b0;
            else                     nxt.x     = cur.x - X_W'(SPEED);
          end
        end
      end

      assign slot_next[gi]      = nxt;
      assign valid_vec[gi]      = cur.valid;
      assign valid_next_vec[gi] = nxt.valid;

      assign slot_valid[gi]           = cur.valid;
      assign slot_owner[gi]           = cur.owner;
      assign slot_x[gi*X_W +: X_W]    = cur.x;
      assign slot_y[gi*X_W +: X_W]    = cur.y;
    end
  endgenerate

  always_ff @(posedge board_clk) begin
    if (!reset) begin
      // Reloading from the live input keeps a key held through reset from firing.
      fire_prev_reg <= fire_req;
      pending_reg   <= '0;
      cooldown_reg  <= '0;
      fire_ack_reg  <= '0;
      slot_reg      <= '0;
      pool_full_reg <= 1'b0;
    end else begin
      fire_prev_reg <= fire_req;
      pending_reg   <= pending_next;
      cooldown_reg  <= cooldown_next;
      fire_ack_reg  <= grant;
      slot_reg      <= slot_next;
      pool_full_reg <= &valid_next_vec;
    end
  end

  assign fire_ack  = fire_ack_reg;
  assign pool_full = pool_full_reg;

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: reset, single shot, ties, full pool,
// same-cycle events, cooldown release and screen-edge exits.
module tb_shot_scheduler;
  import shot_scheduler_pkg::*;

  logic                 board_clk;
  logic                 reset;
  logic                 tick;
  logic [1:0]           fire_req;
  logic [X_W-1:0]       p1_y, p2_y;
  logic [SLOTS-1:0]     hit_clr;
  logic [1:0]           fire_ack;
  logic [SLOTS-1:0]     slot_valid, slot_owner;
  logic [SLOTS*X_W-1:0] slot_x, slot_y;
  logic                 pool_full;

  int n_checks = 0;
  int n_fails  = 0;

  shot_scheduler dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .tick       (tick),
    .fire_req   (fire_req),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .hit_clr    (hit_clr),
    .fire_ack   (fire_ack),
    .slot_valid (slot_valid),
    .slot_owner (slot_owner),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .pool_full  (pool_full)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [X_W-1:0] sx(input int i);
    return slot_x[i*X_W +: X_W];
  endfunction

  function automatic logic [X_W-1:0] sy(input int i);
    return slot_y[i*X_W +: X_W];
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge board_clk);
    @(negedge board_clk);
  endtask

  task automatic frame();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    fire_req = 2'b11;
    p1_y     = '0;
    p2_y     = '0;
    hit_clr  = '0;

    // Reset held with both keys down
    @(negedge board_clk);
    repeat (3) cyc();
    chk("rst_ack", fire_ack, 0);
    chk("rst_valid", slot_valid, 0);
    chk("rst_owner", slot_owner, 0);
    chk("rst_x", slot_x[31:0], 0);
    chk("rst_y", slot_y[31:0], 0);
    chk("rst_full", pool_full, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("held_no_ack", fire_ack, 0);
    end
    chk("held_valid", slot_valid, 0);

    // Single p1 shot
    fire_req = 2'b00;
    cyc();
    p1_y = 10'd120;
    p2_y = 10'd200;
    fire_req = 2'b01;
    cyc();
    chk("s_ack_early", fire_ack, 0);
    cyc();
    chk("s_ack", fire_ack, 2'b01);
    chk("s_valid", slot_valid, 4'b0001);
    chk("s_owner", slot_owner, 4'b0000);
    chk("s_x0", sx(0), 40);
    chk("s_y0", sy(0), 120);
    cyc();
    chk("s_ack_pulse", fire_ack, 0);
    repeat (5) frame();
    chk("s_x0_5tick", sx(0), 60);
    repeat (3) frame();
    hit_clr = 4'b0001;
    cyc();
    hit_clr = '0;
    chk("s_hit", slot_valid, 0);

    // Tie: p1 first, then p2
    fire_req = 2'b00;
    cyc();
    fire_req = 2'b11;
    cyc();
    cyc();
    chk("t1_ack", fire_ack, 2'b01);
    chk("t1_valid", slot_valid, 4'b0001);
    chk("t1_x0", sx(0), 40);
    cyc();
    chk("t1_ack_p2", fire_ack, 2'b10);
    chk("t1_valid2", slot_valid, 4'b0011);
    chk("t1_owner", slot_owner, 4'b0010);
    chk("t1_x1", sx(1), 600);
    chk("t1_y1", sy(1), 200);
    repeat (8) frame();
    chk("t1_x0_mv", sx(0), 72);
    chk("t1_x1_mv", sx(1), 568);
    // Second tie goes to p2
    fire_req = 2'b00;
    cyc();
    fire_req = 2'b11;
    cyc();
    cyc();
    chk("t2_ack", fire_ack, 2'b10);
    chk("t2_valid", slot_valid, 4'b0111);
    chk("t2_x2", sx(2), 600);
    chk("t2_owner", slot_owner, 4'b0110);
    chk("t2_nfull", pool_full, 0);
    cyc();
    chk("t2_ack_p1", fire_ack, 2'b01);
    chk("t2_valid2", slot_valid, 4'b1111);
    chk("t2_x3", sx(3), 40);
    chk("t2_full", pool_full, 1);

    // Full pool: p2 request waits for a freed slot
    repeat (8) frame();
    chk("f_x0", sx(0), 104);
    chk("f_x3", sx(3), 72);
    fire_req = 2'b01;
    cyc();
    fire_req = 2'b11;
    cyc();
    cyc();
    chk("f_no_ack1", fire_ack, 0);
    cyc();
    chk("f_no_ack2", fire_ack, 0);
    chk("f_full", pool_full, 1);
    hit_clr = 4'b0010;
    cyc();
    hit_clr = '0;
    chk("f_freed", slot_valid, 4'b1101);
    chk("f_nfull", pool_full, 0);
    chk("f_no_ack3", fire_ack, 0);
    cyc();
    chk("f_ack", fire_ack, 2'b10);
    chk("f_valid", slot_valid, 4'b1111);
    chk("f_x1", sx(1), 600);
    chk("f_owner", slot_owner, 4'b0110);
    chk("f_full2", pool_full, 1);

    // hit_clr and tick together: freed, not moved; others move
    hit_clr = 4'b0001;
    tick = 1'b1;
    cyc();
    hit_clr = '0;
    tick = 1'b0;
    chk("e_hit_tick", slot_valid, 4'b1110);
    chk("e_x1", sx(1), 596);
    chk("e_x3", sx(3), 76);
    // Grant on a tick edge keeps launch x
    fire_req = 2'b10;
    cyc();
    fire_req = 2'b11;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("e_gt_ack", fire_ack, 2'b01);
    chk("e_gt_x0", sx(0), 40);
    chk("e_gt_y0", sy(0), 120);
    chk("e_gt_x3", sx(3), 80);
    chk("e_gt_valid", slot_valid, 4'b1111);
    // Request during cooldown is granted right after the counter empties
    hit_clr = 4'b1000;
    cyc();
    hit_clr = '0;
    chk("e_free3", slot_valid, 4'b0111);
    fire_req = 2'b10;
    cyc();
    fire_req = 2'b11;
    cyc();
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("cd_tick", fire_ack, 0);
      cyc();
      chk("cd_after", fire_ack, (i == 7) ? 2'b01 : 2'b00);
    end
    chk("cd_valid", slot_valid, 4'b1111);
    chk("cd_x3", sx(3), 40);

    // Screen-edge exits
    hit_clr = 4'b1111;
    cyc();
    hit_clr = '0;
    chk("b_clear", slot_valid, 0);
    chk("b_nfull", pool_full, 0);
    repeat (8) frame();
    fire_req = 2'b00;
    cyc();
    fire_req = 2'b11;
    cyc();
    cyc();
    chk("b_ack_p1", fire_ack, 2'b01);
    cyc();
    chk("b_ack_p2", fire_ack, 2'b10);
    chk("b_valid", slot_valid, 4'b0011);
    repeat (149) frame();
    chk("b_x0_636", sx(0), 636);
    chk("b_x1_4", sx(1), 4);
    chk("b_valid2", slot_valid, 4'b0011);
    frame();
    chk("b_p1_exit", slot_valid, 4'b0010);
    chk("b_x1_0", sx(1), 0);
    frame();
    chk("b_p2_exit", slot_valid, 4'b0000);
    chk("b_x1_nowrap", sx(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
